// File: rtl/execute_pkg.sv
// Shared opcode constants and FSM state encoding for the execute stage.
// Used by the execute unit and by the decode stage.
// Pure declarations; no logic.
package execute_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier datapath: accumulator, multiplicand, multiplier, bit counter.
// One multiplier bit per step; WIDTH steps per product.
// No backpressure: the controller decides when to load and step.
module iterative_multiplier
    import execute_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_multiplicand,
    input  logic [WIDTH-1:0] i_multiplier,
    output logic [WIDTH-1:0] o_acc_next,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;

    // Accumulator value after the current step; on the last step this is the product.
    assign o_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_last     = (r_count == CW'(WIDTH - 1));

    // Load operands and clear state, or advance one multiplier bit per step.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_multiplicand;
            r_mplier <= i_multiplier;
            r_count  <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiply.
// Latency 1 for logic/arith ops, MEM_WORD_SIZE+1 for MUL.
// start is ignored (not queued) while busy; no output backpressure.
module execute_unit
    import execute_pkg::*;
#(
    parameter int MEM_WORD_SIZE    = 64,
    parameter int REG_ADDRESS_SIZE = 2
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        start,
    input  logic [2:0]                  opcode,
    input  logic [REG_ADDRESS_SIZE-1:0] dest,
    input  logic [MEM_WORD_SIZE-1:0]    operandA,
    input  logic [MEM_WORD_SIZE-1:0]    operandB,
    output logic                        busy,
    output logic                        done,
    output logic                        writeEnable,
    output logic [MEM_WORD_SIZE-1:0]    result,
    output logic [REG_ADDRESS_SIZE-1:0] writeSel
);

    localparam int SHW = $clog2(MEM_WORD_SIZE);

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        w_load;
    logic                        w_step;
    logic                        w_alu_done;
    logic                        w_mul_done;
    logic [MEM_WORD_SIZE-1:0]    w_alu;
    logic [MEM_WORD_SIZE-1:0]    w_acc_next;
    logic                        w_last;
    logic [SHW-1:0]              w_shamt;
    logic [MEM_WORD_SIZE-1:0]    r_result;
    logic [REG_ADDRESS_SIZE-1:0] r_write_sel;
    logic [REG_ADDRESS_SIZE-1:0] r_dest;
    logic                        r_done;

    // Only the low log2(width) bits of B form the shift distance.
    assign w_shamt = operandB[SHW-1:0];

    iterative_multiplier #(
        .WIDTH(MEM_WORD_SIZE)
    ) u_mul (
        .clk           (clk),
        .resetN        (resetN),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_multiplicand(operandA),
        .i_multiplier  (operandB),
        .o_acc_next    (w_acc_next),
        .o_last        (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next state and control: accept starts only in IDLE, step the multiplier in MUL.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_alu_done   = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        w_load       = 1'b1;
                        w_state_next = ST_MUL;
                    end else begin
                        w_alu_done = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_mul_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Single-cycle ALU; MUL is handled by the iterative datapath.
    always_comb begin
        w_alu = '0;
        case (opcode)
            OP_ADD:  w_alu = operandA + operandB;
            OP_SUB:  w_alu = operandA - operandB;
            OP_AND:  w_alu = operandA & operandB;
            OP_OR:   w_alu = operandA | operandB;
            OP_XOR:  w_alu = operandA ^ operandB;
            OP_SHL:  w_alu = operandA << w_shamt;
            OP_SHR:  w_alu = operandA >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    // Output registers: result/writeSel held between completions, done pulses once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_result    <= '0;
            r_write_sel <= '0;
            r_dest      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_alu_done | w_mul_done;
            if (w_load) r_dest <= dest;
            if (w_alu_done) begin
                r_result    <= w_alu;
                r_write_sel <= dest;
            end else if (w_mul_done) begin
                r_result    <= w_acc_next;
                r_write_sel <= r_dest;
            end
        end
    end

    assign busy        = (r_state == ST_MUL);
    assign done        = r_done;
    assign writeEnable = r_done;
    assign result      = r_result;
    assign writeSel    = r_write_sel;

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

    localparam int W  = 64;
    localparam int RA = 2;

    logic          clk = 1'b0;
    logic          resetN;
    logic          start;
    logic [2:0]    opcode;
    logic [RA-1:0] dest;
    logic [W-1:0]  operandA;
    logic [W-1:0]  operandB;
    logic          busy;
    logic          done;
    logic          writeEnable;
    logic [W-1:0]  result;
    logic [RA-1:0] writeSel;

    execute_unit #(
        .MEM_WORD_SIZE   (W),
        .REG_ADDRESS_SIZE(RA)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .opcode     (opcode),
        .dest       (dest),
        .operandA   (operandA),
        .operandB   (operandB),
        .busy       (busy),
        .done       (done),
        .writeEnable(writeEnable),
        .result     (result),
        .writeSel   (writeSel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [RA-1:0] d;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: the operation as plain modular arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] sh;
        sh = b % W;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: return a * b;
            default: return a >> sh;
        endcase
    endfunction

    // Issue one op and wait for its completion; leaves the bench in the done cycle.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [RA-1:0] d, input logic [W-1:0] exp);
        int cyc;
        int busy_cnt;
        opcode   = op;
        operandA = a;
        operandB = b;
        dest     = d;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        if (op == 3'b110) begin
            cyc      = 1;
            busy_cnt = 0;
            while (!done && cyc < 200) begin
                if (busy) busy_cnt++;
                tick();
                cyc++;
            end
            check({name, " mul latency"}, W'(cyc), W'(W + 1));
            check({name, " busy cycles"}, W'(busy_cnt), W'(W));
            check({name, " busy in done cycle"}, W'(busy), W'(0));
        end
        check({name, " done"}, W'(done), W'(1));
        check({name, " writeEnable"}, W'(writeEnable), W'(1));
        check({name, " result"}, result, exp);
        check({name, " writeSel"}, W'(writeSel), W'(d));
    endtask

    initial begin
        int ndone;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        logic [RA-1:0] rd;

        vt[0] = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd3, 64'd0};
        vt[1] = '{3'd1, 64'd5, 64'd7, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        vt[2] = '{3'd5, 64'd1, 64'h43, 2'd1, 64'd8};
        vt[3] = '{3'd2, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 2'd2, 64'h0F00_0F00_0F00_0F00};
        vt[4] = '{3'd3, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 2'd3, 64'hFFF0_FFF0_FFF0_FFF0};
        vt[5] = '{3'd4, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 2'd1, 64'hF0F0_F0F0_F0F0_F0F0};
        vt[6] = '{3'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF7F, 2'd1, 64'd1};
        vt[7] = '{3'd6, 64'hAAAA_AAAA_AAAA_AAAA, 64'd3, 2'd2, 64'hFFFF_FFFF_FFFF_FFFE};

        // Reset then idle.
        resetN   = 1'b0;
        start    = 1'b0;
        opcode   = '0;
        dest     = '0;
        operandA = '0;
        operandB = '0;
        tick();
        tick();
        check("reset result", result, 64'd0);
        check("reset writeSel", W'(writeSel), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset busy", W'(busy), W'(0));
        resetN = 1'b1;
        ndone  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (writeEnable) ndone++;
        end
        check("idle writeEnable count", W'(ndone), W'(0));

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].exp);
            tick();
            check($sformatf("vec%0d single pulse", i), W'(done), W'(0));
            check($sformatf("vec%0d result held", i), result, vt[i].exp);
        end

        // SUB then SHL back-to-back: consecutive done pulses.
        opcode = 3'd1; operandA = 64'd5; operandB = 64'd7; dest = 2'd0; start = 1'b1;
        tick();
        check("b2b sub done", W'(done), W'(1));
        check("b2b sub result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        opcode = 3'd5; operandA = 64'd1; operandB = 64'h43; dest = 2'd3;
        tick();
        start = 1'b0;
        check("b2b shl done", W'(done), W'(1));
        check("b2b shl result", result, 64'd8);
        check("b2b shl writeSel", W'(writeSel), W'(3));
        tick();
        check("b2b after done", W'(done), W'(0));

        // Start ignored while busy.
        opcode = 3'd6; operandA = 64'h10; operandB = 64'h10; dest = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 10) begin
                opcode = 3'd0; operandA = 64'd1; operandB = 64'd1; dest = 2'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                check("ignore result", result, 64'h100);
                check("ignore writeSel", W'(writeSel), W'(1));
            end
            tick();
        end
        start = 1'b0;
        check("ignore done count", W'(ndone), W'(1));

        // Reset mid-multiply.
        opcode = 3'd6; operandA = 64'd3; operandB = 64'd5; dest = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        check("midmul busy before reset", W'(busy), W'(1));
        resetN = 1'b0;
        #1;
        check("midmul reset result", result, 64'd0);
        check("midmul reset writeSel", W'(writeSel), W'(0));
        check("midmul reset busy", W'(busy), W'(0));
        check("midmul reset done", W'(done), W'(0));
        tick();
        tick();
        resetN = 1'b1;
        ndone  = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done || writeEnable) ndone++;
        end
        check("midmul no done after release", W'(ndone), W'(0));
        run_op("post reset add", 3'd0, 64'd2, 64'd2, 2'd2, 64'd4);

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = (i % 3 == 0) ? W'($urandom_range(0, 200)) : {$urandom, $urandom};
            rd  = RA'($urandom_range(0, 3));
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rd, model(rop, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
